// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, frame opcodes
// and the payload width.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    WAIT  = 3'd4,
    RECV  = 3'd5,
    TAIL  = 3'd6
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spi_master.sv
// SPI master: sends a 10-bit command frame MSB first, and for read-data
// frames waits MISO_DELAY cycles and then clocks in one byte from MISO.
// SS_n and MOSI are registered and are driven from the next state, so they
// line up with the state the FSM is in during each cycle.
module spi_master #(
  parameter int MISO_DELAY  = 2,
  parameter int SS_HIGH_MIN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  import spi_pkg::*;

  localparam logic [3:0] LAST_SHIFT = 4'(FRAME_BITS - 1);
  localparam logic [3:0] LAST_WAIT  = 4'(MISO_DELAY - 1);
  localparam logic [3:0] LAST_RECV  = 4'd7;
  localparam logic [3:0] LAST_TAIL  = 4'(SS_HIGH_MIN - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  shreg_q, shreg_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ssn_q, ssn_d;
  logic        mosi_q, mosi_d;

  // State register plus the datapath registers that move with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      shreg_q   <= 10'd0;
      rd_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next state; the shift register rotates so the opcode is intact after SHIFT
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (start) begin
          shreg_d = cmd;
          state_d = CMD;
        end
      end
      CMD: begin
        cnt_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {shreg_q[8:0], shreg_q[9]};
        if (cnt_q == LAST_SHIFT) begin
          cnt_d   = 4'd0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        cnt_d   = 4'd0;
        state_d = (shreg_q[9:8] == OP_RD_DATA) ? WAIT : TAIL;
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          cnt_d   = 4'd0;
          state_d = RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECV: begin
        rd_data_d = {rd_data_q[6:0], MISO};
        if (cnt_q == LAST_RECV) begin
          cnt_d   = 4'd0;
          state_d = TAIL;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      TAIL: begin
        if (cnt_q == LAST_TAIL) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs and next values for the registered serial pins
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == TAIL) && (cnt_q == LAST_TAIL);
    rd_valid = done && (shreg_q[9:8] == OP_RD_DATA);
    ssn_d    = (state_d == IDLE) || (state_d == TAIL);
    mosi_d   = ((state_d == CMD) || (state_d == SHIFT)) ? shreg_d[9] : 1'b0;
  end

  // Serial pin registers; reset forces SS_n high at once to abort a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssn_q  <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      ssn_q  <= ssn_d;
      mosi_q <= mosi_d;
    end
  end

  assign SS_n    = ssn_q;
  assign MOSI    = mosi_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: every frame is compared against a
// reference built from the frame rules (window length, MOSI bit order,
// MISO sample positions, tail length) rather than from the FSM.
module tb_spi_master;

  localparam int D = 3;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] cmd;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int checkCount = 0;
  int passCount  = 0;
  logic [7:0] expRdData = 8'd0;

  spi_master #(.MISO_DELAY(D), .SS_HIGH_MIN(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      passCount++;
  endtask

  // Runs one frame for command c. If preStarted, start/cmd are already driven.
  // injectAt >= 0 pulses a stray start with a random cmd at that frame cycle.
  task automatic applyStimulus(input logic [9:0] c, input int injectAt, input bit preStarted);
    logic [11:0] mosiObs;
    logic [11:0] mosiExp;
    logic        misoAt[0:63];
    int          lowLen;
    int          tailLen;
    bit          seenLow;
    bit          gotDone;
    logic        validAtDone;
    logic [7:0]  rxExp;
    bit          isRead;
    mosiObs = '0;
    lowLen  = 0;
    tailLen = 0;
    seenLow = 0;
    gotDone = 0;
    validAtDone = 1'b0;
    isRead = (c[9:8] == 2'b11);
    for (int i = 0; i < 64; i++) misoAt[i] = 1'b0;
    if (!preStarted) begin
      @(posedge clk); #1;
      start = 1'b1;
      cmd   = c;
    end
    @(posedge clk); #1;
    start = 1'b0;
    MISO  = 1'($urandom);
    for (int cyc = 0; cyc < 100 && !gotDone; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checkOutput("busyAfterStart", busy, 1);
        checkOutput("ssnLowFirst", SS_n, 0);
      end
      if (SS_n == 1'b0) begin
        if (lowLen < 12) mosiObs[11 - lowLen] = MOSI;
        if (lowLen < 64) misoAt[lowLen] = MISO;
        lowLen++;
        seenLow = 1;
      end else if (seenLow) begin
        tailLen++;
      end
      if (done) begin
        gotDone = 1;
        validAtDone = rd_valid;
      end else begin
        @(posedge clk); #1;
        MISO  = 1'($urandom);
        start = (cyc == injectAt) ? 1'b1 : 1'b0;
        if (start) cmd = 10'($urandom);
      end
    end
    start = 1'b0;
    if (!gotDone) begin
      checkOutput("frameDoneTimeout", 0, 1);
      return;
    end
    mosiExp = {c[9], c, 1'b0};
    checkOutput("lowWindowLen", lowLen, isRead ? (12 + D + 8) : 12);
    checkOutput("mosiSequence", mosiObs, mosiExp);
    checkOutput("tailLen", tailLen, H);
    checkOutput("rdValidAtDone", validAtDone, isRead);
    if (isRead) begin
      for (int k = 0; k < 8; k++) rxExp[7 - k] = misoAt[12 + D + k];
      expRdData = rxExp;
    end
    @(negedge clk);
    checkOutput("busyAfterDone", busy, 0);
    checkOutput("singleDone", done, 0);
    checkOutput("rdData", rd_data, expRdData);
  endtask

  // Aborts a frame with reset during SHIFT and restarts straight out of reset
  task automatic applyResetMidFrame(input logic [9:0] c, input logic [9:0] nextC);
    @(posedge clk); #1;
    start = 1'b1;
    cmd   = c;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    checkOutput("ssnLowBeforeAbort", SS_n, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abortSsn", SS_n, 1);
    checkOutput("abortMosi", MOSI, 0);
    checkOutput("abortBusy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abortNoDone", done, 0);
    end
    expRdData = 8'd0;
    start = 1'b1;
    cmd   = nextC;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(nextC, -1, 1);
  endtask

  // Holds start high and measures SS_n-high gaps between consecutive frames
  task automatic applyBackToBack(input logic [9:0] c);
    logic vals[$];
    int   runs[$];
    int   cur;
    bit   seenLow;
    logic prev;
    @(negedge clk);
    start = 1'b1;
    cmd   = c;
    for (int i = 0; i < 4 * (12 + H + 1) + 10; i++) begin
      @(negedge clk);
      vals.push_back(SS_n);
    end
    start = 1'b0;
    cur = 0;
    seenLow = 0;
    prev = 1'b1;
    foreach (vals[i]) begin
      if (vals[i] == 1'b1) begin
        if (seenLow) cur++;
      end else begin
        if (prev == 1'b1 && seenLow && cur > 0) runs.push_back(cur);
        cur = 0;
        seenLow = 1;
      end
      prev = vals[i];
    end
    checkOutput("b2bGapCount", runs.size() >= 2, 1);
    foreach (runs[i]) checkOutput("b2bGapLen", runs[i], H + 1);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checkOutput("b2bIdle", busy, 0);
  endtask

  initial begin
    logic [9:0] c;
    rst_n = 1'b0;
    start = 1'b0;
    cmd   = 10'd0;
    MISO  = 1'b0;
    #12;
    checkOutput("resetSsn", SS_n, 1);
    checkOutput("resetMosi", MOSI, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetRdValid", rd_valid, 0);
    checkOutput("resetRdData", rd_data, 0);

    start = 1'b1;
    cmd   = 10'h0A5;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(10'h0A5, -1, 1);

    applyStimulus(10'h300, -1, 0);
    applyStimulus(10'h13C, 5, 0);
    applyStimulus(10'h3FF, 5, 0);

    for (int n = 0; n < 20; n++) begin
      c = 10'($urandom);
      applyStimulus(c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1, 0);
    end

    applyResetMidFrame(10'h2A5, 10'h35A);

    c = 10'($urandom);
    c[9:8] = 2'($urandom_range(0, 2));
    applyBackToBack(c);
    applyStimulus(10'h3C3, -1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
